// File: rtl/ram_sp_be_init_if.sv
// Request/response bundle for the single-port byte-enable RAM.
// The requester drives the master side; the RAM is the slave.
interface ram_sp_be_init_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                    cs;
    logic                    we;
    logic                    oe;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    err;
    logic                    init_done;

    modport master (
        output cs, we, oe, be, address, wdata,
        input  rdata, rvalid, err, init_done
    );

    modport slave (
        input  cs, we, oe, be, address, wdata,
        output rdata, rvalid, err, init_done
    );
endinterface

// File: rtl/ram_sp_be_init.sv
// Single-port RAM with byte enables, optional output register and a
// post-reset clear sequencer that fills every word with INIT_VALUE.
module ram_sp_be_init #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sp_be_init_if.slave   bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  in_range;
    logic                  acc;
    logic                  wr;
    logic                  rd;
    logic [IW-1:0]         widx;
    logic [IW-1:0]         pidx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    assign in_range = {1'b0, bus.address} < (ADDR_WIDTH+1)'(RAM_DEPTH);
    assign acc      = (state == READY) && bus.cs;
    assign wr       = acc && bus.we;
    assign rd       = acc && !bus.we && bus.oe;
    assign widx     = bus.address[IW-1:0];
    assign pidx     = ptr[IW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= INIT;
            ptr           <= '0;
            bus.init_done <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        state         <= READY;
                        bus.init_done <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
            endcase
        end
    end

    // Array itself has no reset; the sequencer owns it until READY.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                mem[pidx] <= INIT_VALUE;
            end else if (wr && in_range) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.be[i]) begin
                        mem[widx][8*i +: 8] <= bus.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            bus.err  <= 1'b0;
        end else begin
            rd_valid <= rd;
            bus.err  <= acc && !in_range;
            if (rd) begin
                rd_data <= in_range ? mem[widx] : '0;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    bus.rvalid <= 1'b0;
                    bus.rdata  <= '0;
                end else begin
                    bus.rvalid <= rd_valid;
                    if (rd_valid) begin
                        bus.rdata <= rd_data;
                    end
                end
            end
        end else begin : g_direct
            assign bus.rvalid = rd_valid;
            assign bus.rdata  = rd_data;
        end
    endgenerate
endmodule

// File: tb/tb_ram_sp_be_init.sv
// Scoreboard bench: dut0 is 16 deep with latency 1, dut1 is 12 deep
// with latency 2; both clear to A5A5A5A5 after reset.
module tb_ram_sp_be_init;
    localparam int          D0 = 16;
    localparam int          D1 = 12;
    localparam logic [31:0] IV = 32'hA5A5_A5A5;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n [2] = '{1'b0, 1'b0};

    ram_sp_be_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b0 ();
    ram_sp_be_init_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) b1 ();

    ram_sp_be_init #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(D0),
        .OUT_REG(1'b0), .INIT_VALUE(IV)
    ) dut0 (.clk(clk), .rst_n(rst_n[0]), .bus(b0));

    ram_sp_be_init #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(D1),
        .OUT_REG(1'b1), .INIT_VALUE(IV)
    ) dut1 (.clk(clk), .rst_n(rst_n[1]), .bus(b1));

    logic [31:0] rdo [2];
    logic        rvo [2];
    logic        ero [2];
    logic        ido [2];
    assign rdo[0] = b0.rdata;
    assign rdo[1] = b1.rdata;
    assign rvo[0] = b0.rvalid;
    assign rvo[1] = b1.rvalid;
    assign ero[0] = b0.err;
    assign ero[1] = b1.err;
    assign ido[0] = b0.init_done;
    assign ido[1] = b1.init_done;

    int          cyc     = 0;
    int          cnt [2] = '{0, 0};
    int          nchk    = 0;
    int          nfail   = 0;
    bit          armed   = 1'b0;
    ev_t         rq [2][$];
    int          eq [2][$];
    logic [31:0] hold [2];

    function automatic int dep(int d);
        return (d == 0) ? D0 : D1;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) cnt[d] <= 0;
            else if (cnt[d] < dep(d)) cnt[d] <= cnt[d] + 1;
        end
    end

    task automatic chk(int d, string nm, logic [31:0] a, logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s dut%0d actual=%h expected=%h", nm, d, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                bit erv;
                bit eer;
                erv = 1'b0;
                eer = 1'b0;
                if (rq[d].size() > 0) erv = (rq[d][0].cyc == cyc);
                if (eq[d].size() > 0) eer = (eq[d][0] == cyc);
                chk(d, "rvalid", 32'(rvo[d]), 32'(erv));
                if (erv) begin
                    hold[d] = rq[d][0].d;
                    void'(rq[d].pop_front());
                end
                chk(d, "rdata", rdo[d], hold[d]);
                chk(d, "err", 32'(ero[d]), 32'(eer));
                if (eer) void'(eq[d].pop_front());
                chk(d, "init_done", 32'(ido[d]), 32'(cnt[d] >= dep(d)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(int d, logic we, logic oe, logic [3:0] be,
                       logic [3:0] a, logic [31:0] wd, logic [31:0] ex);
        ev_t e;
        int  s;
        bit  rdy;
        s   = cyc + 1;
        rdy = cnt[d] >= dep(d);
        if (d == 0) begin
            b0.cs = 1'b1; b0.we = we; b0.oe = oe;
            b0.be = be; b0.address = a; b0.wdata = wd;
        end else begin
            b1.cs = 1'b1; b1.we = we; b1.oe = oe;
            b1.be = be; b1.address = a; b1.wdata = wd;
        end
        if (rdy) begin
            if (32'(a) >= dep(d)) eq[d].push_back(s);
            if (!we && oe) begin
                e.cyc = s + lat(d);
                e.d   = ex;
                rq[d].push_back(e);
            end
        end
        step();
        b0.cs = 1'b0;
        b1.cs = 1'b0;
    endtask

    task automatic do_rst(int d);
        b0.cs = 1'b0;
        b1.cs = 1'b0;
        rst_n[d] = 1'b0;
        step();
        rq[d].delete();
        eq[d].delete();
        hold[d]  = '0;
        rst_n[d] = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64; i++) begin
            if (cnt[0] >= D0 && cnt[1] >= D1) break;
            step();
        end
    endtask

    initial begin
        b0.cs = 1'b0; b0.we = 1'b0; b0.oe = 1'b0;
        b0.be = '0; b0.address = '0; b0.wdata = '0;
        b1.cs = 1'b0; b1.we = 1'b0; b1.oe = 1'b0;
        b1.be = '0; b1.address = '0; b1.wdata = '0;
        step();
        hold[0]  = '0;
        hold[1]  = '0;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        armed    = 1'b1;

        // Requests during INIT must be ignored
        req(0, 1'b1, 1'b0, 4'hF, 4'd2, 32'hDEAD_BEEF, 32'h0);
        req(1, 1'b1, 1'b0, 4'hF, 4'd2, 32'hDEAD_BEEF, 32'h0);
        req(1, 1'b0, 1'b1, 4'hF, 4'd2, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (cnt[0] == 5) break;
            step();
        end
        do_rst(0);
        wait_ready();

        for (int i = 0; i < 16; i++)
            req(0, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0, IV);
        step();

        req(0, 1'b1, 1'b0, 4'hF, 4'd3, 32'h1122_3344, 32'h0);
        req(0, 1'b1, 1'b0, 4'h5, 4'd3, 32'hAABB_CCDD, 32'h0);
        req(0, 1'b0, 1'b1, 4'hF, 4'd3, 32'h0, 32'h11BB_33DD);
        step();

        for (int i = 0; i < 8; i++)
            req(0, 1'b1, 1'b0, 4'hF, 4'(i), 32'h0101_0101 * (i + 1), 32'h0);
        for (int i = 0; i < 8; i++)
            req(0, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0, 32'h0101_0101 * (i + 1));
        req(0, 1'b0, 1'b0, 4'hF, 4'd5, 32'h0, 32'h0);
        step();
        req(0, 1'b1, 1'b0, 4'h0, 4'd6, 32'hFFFF_FFFF, 32'h0);
        req(0, 1'b0, 1'b1, 4'hF, 4'd6, 32'h0, 32'h0707_0707);
        step();

        for (int i = 0; i < 12; i++)
            req(1, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0, IV);
        for (int i = 0; i < 8; i++)
            req(1, 1'b1, 1'b0, 4'hF, 4'(i), 32'h1020_3040 + i, 32'h0);
        for (int i = 0; i < 8; i++)
            req(1, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0, 32'h1020_3040 + i);
        req(1, 1'b1, 1'b0, 4'hF, 4'd13, 32'hCAFE_F00D, 32'h0);
        req(1, 1'b0, 1'b1, 4'hF, 4'd13, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++)
            req(1, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0,
                (i < 8) ? 32'h1020_3040 + i : IV);
        req(1, 1'b1, 1'b0, 4'hF, 4'd9, 32'h1234_5678, 32'h0);
        req(1, 1'b0, 1'b1, 4'hF, 4'd9, 32'h0, 32'h1234_5678);
        step();
        step();

        // Read in flight when reset hits: its rvalid must never appear
        req(1, 1'b0, 1'b1, 4'hF, 4'd1, 32'h0, 32'h1020_3041);
        do_rst(1);
        req(1, 1'b1, 1'b0, 4'hF, 4'd0, 32'h0000_0BAD, 32'h0);
        wait_ready();
        for (int i = 0; i < 4; i++)
            req(1, 1'b0, 1'b1, 4'hF, 4'(i), 32'h0, IV);
        repeat (4) step();

        for (int d = 0; d < 2; d++) begin
            chk(d, "drain_rd", 32'(rq[d].size()), 32'h0);
            chk(d, "drain_err", 32'(eq[d].size()), 32'h0);
        end
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/ram_sp_be_init.md
# ram_sp_be_init

Parametrised single-port synchronous RAM with per-byte write enables, an optional output register stage, and a hardware clear sequencer that fills the array after reset. It is the general-purpose on-chip buffer for the practice datapaths. Read and write data are separate unidirectional buses with a read-valid strobe, so no tri-state bus is used.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, address width in bits
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; 2..2^ADDR_WIDTH, need not be a power of two
- OUT_REG, 0, 1 adds a registered output stage (read latency 2 instead of 1)
- INIT_VALUE, 0, word written to every location by the clear sequencer

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- cs  input  1  chip select; no operation when 0
- we  input  1  1 = write, 0 = read (when cs=1)
- oe  input  1  read enable; a read needs cs=1, we=0, oe=1
- be  input  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i]
- address  input  ADDR_WIDTH  word address
- wdata  input  DATA_WIDTH  write data
- rdata  output  DATA_WIDTH  read data; holds its value between reads
- rvalid  output  1  one-cycle pulse aligned with new rdata
- err  output  1  one-cycle pulse: access to address >= RAM_DEPTH
- init_done  output  1  1 once the clear sequence has finished

## Operation
- States: INIT, READY. Reset enters INIT with the clear pointer at 0.
- INIT: each edge writes INIT_VALUE to location ptr (all bytes) and increments ptr. After writing RAM_DEPTH-1 the state moves to READY and init_done goes to 1. cs/we/oe/be are ignored during INIT: no write, no rvalid, no err.
- READY, write (cs=1, we=1): bytes with be[i]=1 are updated; other bytes keep their old value. be=0 is a legal no-op. oe is ignored.
- READY, read (cs=1, we=0, oe=1): mem[address] is returned on rdata with an rvalid pulse.
- READY, cs=1, we=0, oe=0: no operation. rdata and rvalid are unchanged (rvalid=0).
- Out-of-range address (>= RAM_DEPTH) with cs=1 in READY, for any we/oe: err pulses; writes are dropped. An out-of-range read returns rdata=0 with rvalid=1.
- Read-after-write to the same address on consecutive cycles returns the newly written data. There is no same-cycle read/write on a single port.
- Reset values: rdata=0, rvalid=0, err=0, init_done=0, state=INIT. Memory contents are undefined until INIT completes.
- rst_n low at any point, including mid-INIT or mid-read pipeline, restarts INIT from ptr=0 and flushes pending reads. No rvalid is emitted for reads in flight.

## Timing
- Clear takes exactly RAM_DEPTH cycles. The first edge with rst_n=1 writes location 0, and edge k writes location k. init_done is 1 after edge RAM_DEPTH-1.
- The first accepted request is the one sampled on the first edge where init_done is already 1.
- OUT_REG=0: a read sampled on edge N gives rdata/rvalid valid after edge N. Latency is 1.
- OUT_REG=1: the same read gives rdata/rvalid after edge N+1. Latency is 2.
- Both modes accept one request every cycle (full throughput), and reads complete in issue order.
- err is asserted after the edge that samples the offending request, with latency 1 in both modes.
- A write is visible to a read sampled on the next edge.

## Test plan
- Clear check: DATA_WIDTH=32, RAM_DEPTH=16, INIT_VALUE=32'hA5A5A5A5. Release rst_n and count cycles. Required: init_done rises after exactly 16 edges, and reading all 16 addresses returns A5A5A5A5 with one rvalid each.
- Byte enables: write 32'h11223344 to addr 3 with be=4'hF, then 32'hAABBCCDD with be=4'b0101, then read addr 3. Required: rdata=32'h11BB33DD.
- Latency and throughput: OUT_REG=0 and OUT_REG=1, back-to-back reads of addr 0..7 after distinct writes. Required: rvalid high for 8 consecutive cycles, starting 1 (resp. 2) cycles after the first read, with data in order.
- Out-of-range: RAM_DEPTH=12, ADDR_WIDTH=4. Write addr 13, then read addr 13. Required: err pulses twice, the read returns rdata=0 with rvalid=1, and addr 0..11 are unchanged.
- Reset mid-operation: assert rst_n=0 for 1 cycle at ptr=5 during INIT, and separately with a read in flight. Required: init_done=0, the read's rvalid is suppressed, rdata=0, and the full RAM_DEPTH clear is repeated from 0.
- Requests during INIT and the oe=0 read: issue writes during INIT, then cs=1, we=0, oe=0 in READY. Required: memory holds INIT_VALUE everywhere, and there is no rvalid or err.
